// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit execute-stage ALU: data width and opcode map.
package alu_pkg;

  localparam int ALU_W   = 16;
  localparam int SHAMT_W = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU logic/adder chain: bitwise AND/OR/XOR of the raw operands
// plus a full adder whose B input can be inverted for subtraction.
module alu_bit_slice (
  input  logic a,
  input  logic b,
  input  logic bnegate,
  input  logic carry_in,
  output logic and_bit,
  output logic or_bit,
  output logic xor_bit,
  output logic sum,
  output logic carry_out
);

  logic b_eff;
  logic half_sum;

  // Logic functions always use the uninverted B; only the adder sees bnegate.
  assign and_bit  = a & b;
  assign or_bit   = a | b;
  assign xor_bit  = a ^ b;

  assign b_eff     = b ^ bnegate;
  assign half_sum  = a ^ b_eff;
  assign sum       = half_sum ^ carry_in;
  assign carry_out = (a & b_eff) | (carry_in & half_sum);

endmodule

// File: rtl/alu_16.sv
// Registered 16-bit ALU: ripple bit-slice logic/adder, barrel shifters and a
// single-cycle array multiplier feed an opcode mux and one output register.
module alu_16
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  input  logic             bnegate,
  output logic             cout,
  output logic [ALU_W-1:0] result
);

  logic [ALU_W-1:0] and_vec;
  logic [ALU_W-1:0] or_vec;
  logic [ALU_W-1:0] xor_vec;
  logic [ALU_W-1:0] sum_vec;
  logic [ALU_W:0]   carry;
  logic             add_bnegate;
  logic             add_cin;

  logic [SHAMT_W-1:0] shamt;
  logic [ALU_W-1:0]   sll_val;
  logic [ALU_W-1:0]   srl_val;
  logic [ALU_W-1:0]   mul_val;

  logic [ALU_W-1:0] result_p0;
  logic             cout_p0;
  logic [ALU_W-1:0] result_p1;
  logic             cout_p1;

  // Stage p0: combinational core

  // The adder controls only matter for ADD; gating them keeps the chain quiet otherwise.
  assign add_bnegate = (op == OP_ADD) ? bnegate : 1'b0;
  assign add_cin     = (op == OP_ADD) ? cin     : 1'b0;
  assign carry[0]    = add_cin;

  for (genvar i = 0; i < ALU_W; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a         (a[i]),
      .b         (b[i]),
      .bnegate   (add_bnegate),
      .carry_in  (carry[i]),
      .and_bit   (and_vec[i]),
      .or_bit    (or_vec[i]),
      .xor_bit   (xor_vec[i]),
      .sum       (sum_vec[i]),
      .carry_out (carry[i+1])
    );
  end

  // Only the low four bits of B form the shift amount; the rest is ignored.
  assign shamt   = b[SHAMT_W-1:0];
  assign sll_val = a << shamt;
  assign srl_val = a >> shamt;

  // Shift-and-add array multiplier truncated to 16 bits; partial products
  // above bit 15 fall off naturally in the 16-bit accumulation.
  always_comb begin
    mul_val = '0;
    for (int i = 0; i < ALU_W; i++) begin
      if (b[i]) begin
        mul_val = mul_val + (a << i);
      end
    end
  end

  // Opcode mux selecting the next result and carry-out.
  always_comb begin
    result_p0 = '0;
    cout_p0   = 1'b0;
    case (op)
      OP_AND: result_p0 = and_vec;
      OP_SLL: result_p0 = sll_val;
      OP_OR:  result_p0 = or_vec;
      OP_XOR: result_p0 = xor_vec;
      OP_ADD: begin
        result_p0 = sum_vec;
        cout_p0   = carry[ALU_W];
      end
      OP_RSV: result_p0 = '0;
      OP_SRL: result_p0 = srl_val;
      OP_MUL: result_p0 = mul_val;
      default: result_p0 = '0;
    endcase
  end

  // Stage p1: output register, cleared by reset over any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
      cout_p1   <= 1'b0;
    end else begin
      result_p1 <= result_p0;
      cout_p1   <= cout_p0;
    end
  end

  assign result = result_p1;
  assign cout   = cout_p1;

endmodule

// File: tb/tb_alu_16.sv
// Scoreboard bench for alu_16: a driver pushes expected {cout,result} per cycle,
// a monitor pops and compares one cycle later.
module tb_alu_16;

  logic        clk;
  logic        rst;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        bnegate;
  logic        cout;
  logic [15:0] result;

  logic [16:0] exp_q[$];
  string       name_q[$];

  int checks = 0;
  int passes = 0;

  alu_16 dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .bnegate (bnegate),
    .cout    (cout),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: {cout,result} from plain arithmetic on the opcode table.
  function automatic logic [16:0] model(input logic r, input logic [2:0] o,
                                        input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic bn);
    int unsigned prod;
    int unsigned sum;
    int unsigned yy;
    if (r) return 17'h0;
    case (o)
      3'd0: return {1'b0, x & y};
      3'd1: return {1'b0, 16'((32'(x) * (32'd1 << y[3:0])) & 32'hFFFF)};
      3'd2: return {1'b0, x | y};
      3'd3: return {1'b0, x ^ y};
      3'd4: begin
        yy  = bn ? (32'hFFFF - 32'(y)) : 32'(y);
        sum = 32'(x) + yy + 32'(ci);
        return {sum >= 32'h10000, 16'(sum % 32'h10000)};
      end
      3'd6: return {1'b0, 16'(32'(x) / (32'd1 << y[3:0]))};
      3'd7: begin
        prod = 32'(x) * 32'(y);
        return {1'b0, 16'(prod % 32'h10000)};
      end
      default: return 17'h0;
    endcase
  endfunction

  task automatic drive(input logic r, input logic [2:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic ci, input logic bn,
                       input logic [16:0] exp, input string nm);
    @(negedge clk);
    rst = r; op = o; a = x; b = y; cin = ci; bnegate = bn;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic apply(input logic r, input logic [2:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic ci, input logic bn,
                       input string nm);
    drive(r, o, x, y, ci, bn, model(r, o, x, y, ci, bn), nm);
  endtask

  // Monitor: every cycle the output reflects the inputs driven before the previous edge.
  initial begin
    logic [16:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({cout, result} === e) passes++;
        else $display("FAIL %s: got cout=%0b result=%04h, expected cout=%0b result=%04h",
                      nm, cout, result, e[16], e[15:0]);
      end
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [15:0] ra, rb;
    logic        rc, rn;
    rst = 1'b1; op = 3'd0; a = '0; b = '0; cin = 1'b0; bnegate = 1'b0;
    repeat (2) @(posedge clk);

    // Directed cases with hand-derived expectations.
    drive(1, 3'b100, 16'd5,     16'd5,     0, 0, {1'b0, 16'h0000}, "reset");
    drive(0, 3'b000, 16'h000D,  16'h0008,  0, 0, {1'b0, 16'h0008}, "and");
    drive(0, 3'b010, 16'd1,     16'd1,     0, 0, {1'b0, 16'd1},    "or");
    drive(0, 3'b011, 16'd18,    16'd25,    0, 0, {1'b0, 16'd11},   "xor");
    drive(0, 3'b011, 16'd18,    16'd25,    1, 1, {1'b0, 16'd11},   "xor_cin");
    drive(0, 3'b100, 16'd10,    16'd6,     0, 0, {1'b0, 16'd16},   "add");
    drive(0, 3'b100, 16'd1,     16'd1,     1, 1, {1'b1, 16'd0},    "sub_eq");
    drive(0, 3'b100, 16'h0049,  16'h0055,  1, 1, {1'b0, 16'hFFF4}, "sub_borrow");
    drive(0, 3'b100, 16'hFFFF,  16'd1,     0, 0, {1'b1, 16'd0},    "add_wrap");
    drive(0, 3'b001, 16'd29,    16'h0055,  0, 0, {1'b0, 16'd928},  "sll5");
    drive(0, 3'b001, 16'h00FF,  16'd10,    0, 0, {1'b0, 16'hFC00}, "sll10");
    drive(0, 3'b110, 16'd30,    16'd13,    0, 0, {1'b0, 16'd0},    "srl13");
    drive(0, 3'b110, 16'h8000,  16'd15,    0, 0, {1'b0, 16'd1},    "srl15");
    drive(0, 3'b111, 16'd20,    16'd10,    1, 1, {1'b0, 16'd200},  "mul_a");
    drive(0, 3'b111, 16'd9,     16'd17,    0, 0, {1'b0, 16'd153},  "mul_b");
    drive(0, 3'b111, 16'h0100,  16'h0100,  0, 0, {1'b0, 16'h0000}, "mul_trunc");
    drive(0, 3'b101, 16'hFFFF,  16'hFFFF,  1, 1, {1'b0, 16'h0000}, "reserved");
    drive(1, 3'b111, 16'hFFFF,  16'hFFFF,  0, 0, {1'b0, 16'h0000}, "reset_mid");

    // Back-to-back ADD / MUL alternation.
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rn = 1'($urandom);
      apply(0, (i % 2 == 0) ? 3'b100 : 3'b111, ra, rb, rc, rn, "alt_add_mul");
    end

    // Random mix over all opcodes, with occasional reset.
    for (int i = 0; i < 400; i++) begin
      ro = 3'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rn = 1'($urandom);
      if (i % 5 == 0) ra = 16'hFFFF;
      apply(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, ro, ra, rb, rc, rn, "random");
    end

    @(negedge clk);
    rst = 1'b0; op = 3'd0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
